// File: rtl/relu_maxpool_2x2_if.sv
// Stream bundle for relu_maxpool_2x2: frame control, raw conv-sum input, pooled pixel output.
// RELU_POOL_SAT_CNT_EN adds the sat_cnt observation bus.
interface relu_maxpool_2x2_if;
    logic               frame_start;
    logic signed [15:0] bias_in;
    logic               in_valid;
    logic signed [35:0] in_data;
    logic               out_valid;
    logic        [7:0]  out_data;
    logic        [7:0]  out_row;
    logic        [7:0]  out_col;
    logic               frame_done;
    logic               busy;
`ifdef RELU_POOL_SAT_CNT_EN
    logic        [17:0] sat_cnt;
`endif

    modport master (
        output frame_start, bias_in, in_valid, in_data,
        input  out_valid, out_data, out_row, out_col, frame_done, busy
`ifdef RELU_POOL_SAT_CNT_EN
        , input sat_cnt
`endif
    );

    modport slave (
        input  frame_start, bias_in, in_valid, in_data,
        output out_valid, out_data, out_row, out_col, frame_done, busy
`ifdef RELU_POOL_SAT_CNT_EN
        , output sat_cnt
`endif
    );
endinterface

// File: rtl/relu_maxpool_2x2.sv
// Bias + ReLU + shift/saturate to 8 bits, then 2x2 stride-2 max pooling of a raster conv-sum stream.
// Optional saturated-pixel counter enabled by macro RELU_POOL_SAT_CNT_EN.
module relu_maxpool_2x2 #(
    parameter int unsigned IMG_W = 224,
    parameter int unsigned IMG_H = 224,
    parameter int unsigned SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    relu_maxpool_2x2_if.slave  bus
);
    localparam int unsigned CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned HCW = (IMG_W > 4) ? $clog2(IMG_W / 2) : 1;
    localparam int unsigned HRW = (IMG_H > 4) ? $clog2(IMG_H / 2) : 1;
    localparam int unsigned SW  = 37;
    localparam int unsigned PW  = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       col, col_cur_c;
    logic [RW-1:0]       row, row_cur_c;
    logic signed [15:0]  bias, bias_cur_c;
    logic                accept_c, col_end_c, last_beat_c;

    logic signed [SW-1:0] sum_c;
    logic [SW-1:0]        relu_c, shift_c;
    logic                 sat_c;
    logic [PW-1:0]        q_c;

    logic                s1_valid, s1_col_odd, s1_row_odd, s1_last;
    logic [PW-1:0]       s1_q;
    logic [HCW-1:0]      s1_hcol;
    logic [HRW-1:0]      s1_hrow;

    logic [PW-1:0]       h_reg, hmax_c, rd_c, pool_c;
    logic                s2_en_c, fire_c;
    logic [PW-1:0]       row_buf [IMG_W/2];

    logic                out_valid, frame_done, busy;
    logic [PW-1:0]       out_data, out_row, out_col;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state: frame_start wins from any state
    always_comb begin
        state_nxt = state;
        if (bus.frame_start)
            state_nxt = RUN;
        else if (state == RUN && accept_c && last_beat_c)
            state_nxt = DONE;
    end

    // FSM outputs: a frame_start beat is pixel (0,0) using this cycle's bias
    always_comb begin
        accept_c   = 1'b0;
        col_cur_c  = col;
        row_cur_c  = row;
        bias_cur_c = bias;
        if (bus.frame_start) begin
            col_cur_c  = '0;
            row_cur_c  = '0;
            bias_cur_c = bus.bias_in;
        end
        if (bus.in_valid && (bus.frame_start || state == RUN))
            accept_c = 1'b1;
    end

    assign col_end_c   = (col_cur_c == CW'(IMG_W - 1));
    assign last_beat_c = col_end_c && (row_cur_c == RW'(IMG_H - 1));

    // Raster position counters and latched bias
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            row  <= '0;
            bias <= '0;
        end else begin
            if (bus.frame_start)
                bias <= bus.bias_in;
            if (accept_c) begin
                if (col_end_c) begin
                    col <= '0;
                    row <= last_beat_c ? '0 : row_cur_c + RW'(1);
                end else begin
                    col <= col_cur_c + CW'(1);
                    row <= row_cur_c;
                end
            end else if (bus.frame_start) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // Bias, ReLU, rescale and clamp to 8 bits
    always_comb begin
        sum_c   = SW'(bus.in_data) + SW'(bias_cur_c);
        relu_c  = sum_c[SW-1] ? '0 : sum_c;
        shift_c = relu_c >> SHIFT;
        sat_c   = |shift_c[SW-1:PW];
        q_c     = sat_c ? '1 : shift_c[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_q       <= '0;
            s1_col_odd <= 1'b0;
            s1_row_odd <= 1'b0;
            s1_hcol    <= '0;
            s1_hrow    <= '0;
            s1_last    <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_q       <= q_c;
                s1_col_odd <= col_cur_c[0];
                s1_row_odd <= row_cur_c[0];
                s1_hcol    <= HCW'(col_cur_c >> 1);
                s1_hrow    <= HRW'(row_cur_c >> 1);
                s1_last    <= last_beat_c;
            end
        end
    end

    // Stage 2: a frame_start discards whatever stage 1 holds from the old frame
    assign s2_en_c = s1_valid && !bus.frame_start;
    assign fire_c  = s2_en_c && s1_col_odd && s1_row_odd;
    assign hmax_c  = (s1_q > h_reg) ? s1_q : h_reg;
    assign rd_c    = row_buf[s1_hcol];
    assign pool_c  = (rd_c > hmax_c) ? rd_c : hmax_c;

    always_ff @(posedge clk) begin
        if (s2_en_c && s1_col_odd && !s1_row_odd)
            row_buf[s1_hcol] <= hmax_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_reg      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            out_valid  <= fire_c;
            frame_done <= fire_c && s1_last;
            busy       <= (state_nxt == RUN);
            if (s2_en_c && !s1_col_odd)
                h_reg <= s1_q;
            if (fire_c) begin
                out_data <= pool_c;
                out_row  <= 8'(s1_hrow);
                out_col  <= 8'(s1_hcol);
            end
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.out_row    = out_row;
    assign bus.out_col    = out_col;
    assign bus.frame_done = frame_done;
    assign bus.busy       = busy;

`ifdef RELU_POOL_SAT_CNT_EN
    logic [17:0] sat_cnt;

    // Per-frame count of clamped pixels, sticky at full scale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_cnt <= '0;
        else if (bus.frame_start)
            sat_cnt <= 18'(accept_c && sat_c);
        else if (accept_c && sat_c && sat_cnt != '1)
            sat_cnt <= sat_cnt + 18'd1;
    end

    assign bus.sat_cnt = sat_cnt;
`endif
endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed self-checking bench for relu_maxpool_2x2 on a 4x4 frame, SHIFT=4.
module tb_relu_maxpool_2x2;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned SHIFT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   stray_done = 0;

    typedef struct { int cyc; logic [7:0] d; logic [7:0] r; logic [7:0] c; logic done; } obs_t;
    typedef struct { int b; logic [7:0] d; logic [7:0] r; logic [7:0] c; logic done; } exp_t;

    obs_t mon_q[$];
    exp_t exp_q[$];
    int   beat_q[$];
    logic signed [35:0] pix [16];

    relu_maxpool_2x2_if bus ();

    relu_maxpool_2x2 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (bus.out_valid)
            mon_q.push_back('{edge_n, bus.out_data, bus.out_row, bus.out_col, bus.frame_done});
        if (bus.frame_done && !bus.out_valid)
            stray_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input int b, input logic [7:0] d, input logic [7:0] r,
                                     input logic [7:0] c, input logic done);
        exp_q.push_back('{b, d, r, c, done});
    endfunction

    // Four pooled outputs of a 4x4 frame whose beat 0 is beat_q[base]
    function automatic void push_std(input int base, input logic [7:0] v0, input logic [7:0] v1,
                                     input logic [7:0] v2, input logic [7:0] v3);
        push_exp(base + 5,  v0, 8'd0, 8'd0, 1'b0);
        push_exp(base + 7,  v1, 8'd0, 8'd1, 1'b0);
        push_exp(base + 13, v2, 8'd1, 8'd0, 1'b0);
        push_exp(base + 15, v3, 8'd1, 8'd1, 1'b1);
    endfunction

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) pix[k] = 36'(16 * k);
    endtask

    task automatic set_const(input logic signed [35:0] v);
        for (int k = 0; k < 16; k++) pix[k] = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bias_in carries junk except on the frame_start beat
    task automatic send_frame(input logic signed [15:0] bias, input bit with_start,
                              input bit gap, input int nb);
        for (int k = 0; k < nb; k++) begin
            bus.frame_start = with_start && (k == 0);
            bus.bias_in     = (with_start && k == 0) ? bias : 16'sh7FFF;
            bus.in_valid    = 1'b1;
            bus.in_data     = pix[k];
            beat_q.push_back(edge_n);
            step(1);
            bus.frame_start = 1'b0;
            bus.in_valid    = 1'b0;
            bus.in_data     = '0;
            if (gap) step(2);
        end
    endtask

    task automatic check_outputs(input string name);
        check({name, ".count"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d].data", name, i), 32'(mon_q[i].d), 32'(exp_q[i].d));
            check($sformatf("%s[%0d].row", name, i),  32'(mon_q[i].r), 32'(exp_q[i].r));
            check($sformatf("%s[%0d].col", name, i),  32'(mon_q[i].c), 32'(exp_q[i].c));
            check($sformatf("%s[%0d].done", name, i), 32'(mon_q[i].done), 32'(exp_q[i].done));
            check($sformatf("%s[%0d].lat", name, i),
                  32'(mon_q[i].cyc - beat_q[exp_q[i].b]), 32'd2);
        end
        mon_q.delete();
        exp_q.delete();
        beat_q.delete();
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, ".out_valid"},  32'(bus.out_valid), 32'd0);
        check({name, ".out_data"},   32'(bus.out_data), 32'd0);
        check({name, ".out_row"},    32'(bus.out_row), 32'd0);
        check({name, ".out_col"},    32'(bus.out_col), 32'd0);
        check({name, ".frame_done"}, 32'(bus.frame_done), 32'd0);
        check({name, ".busy"},       32'(bus.busy), 32'd0);
`ifdef RELU_POOL_SAT_CNT_EN
        check({name, ".sat_cnt"},    32'(bus.sat_cnt), 32'd0);
`endif
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.bias_in     = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        #1 rst = 1'b0;
        #2;
        check_zero_outputs("reset");
        #9 rst = 1'b1;
        step(1);

        // Ramp q=k with a standalone frame_start cycle
        set_ramp();
        bus.frame_start = 1'b1;
        bus.bias_in     = 16'sd0;
        step(1);
        bus.frame_start = 1'b0;
        check("ramp.busy_start", 32'(bus.busy), 32'd1);
        send_frame(16'sd0, 1'b0, 1'b0, 16);
        check("ramp.busy_end", 32'(bus.busy), 32'd0);
        step(4);
        push_std(0, 8'd5, 8'd7, 8'd13, 8'd15);
        check_outputs("ramp");

        // ReLU and bias handling
        set_const(36'sd16);
        send_frame(-16'sd32, 1'b1, 1'b0, 16);
        step(4);
        push_std(0, 8'd0, 8'd0, 8'd0, 8'd0);
        check_outputs("relu_neg");

        set_const(-36'sd16);
        send_frame(16'sd16, 1'b1, 1'b0, 16);
        step(4);
        push_std(0, 8'd0, 8'd0, 8'd0, 8'd0);
        check_outputs("relu_zero");

        set_const(36'sd16);
        send_frame(16'sd16, 1'b1, 1'b0, 16);
        step(4);
        push_std(0, 8'd2, 8'd2, 8'd2, 8'd2);
        check_outputs("relu_pos");

        // Saturation to 255
        set_const(36'sh0_0001_0000);
        send_frame(16'sd0, 1'b1, 1'b0, 16);
        step(4);
        push_std(0, 8'd255, 8'd255, 8'd255, 8'd255);
        check_outputs("sat");
`ifdef RELU_POOL_SAT_CNT_EN
        check("sat.sat_cnt", 32'(bus.sat_cnt), 32'd16);
`endif

        // in_valid after the frame without frame_start is ignored
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pix[k];
            step(1);
            bus.in_valid = 1'b0;
        end
        step(4);
        check("idle.count",    32'(mon_q.size()), 32'd0);
        check("idle.out_data", 32'(bus.out_data), 32'd255);
        check("idle.out_row",  32'(bus.out_row), 32'd1);
        check("idle.out_col",  32'(bus.out_col), 32'd1);
        check("idle.busy",     32'(bus.busy), 32'd0);
`ifdef RELU_POOL_SAT_CNT_EN
        check("idle.sat_cnt",  32'(bus.sat_cnt), 32'd16);
`endif
        mon_q.delete();

        // Gapped input: 1,0,0,1,0,0,...
        set_ramp();
        send_frame(16'sd0, 1'b1, 1'b1, 16);
        step(4);
        push_std(0, 8'd5, 8'd7, 8'd13, 8'd15);
        check_outputs("gap");

        // Abort at beat 9 with the new frame's pixel (0,0)
        send_frame(16'sd0, 1'b1, 1'b0, 9);
        send_frame(16'sd0, 1'b1, 1'b0, 16);
        step(4);
        push_exp(5, 8'd5, 8'd0, 8'd0, 1'b0);
        push_exp(7, 8'd7, 8'd0, 8'd1, 1'b0);
        push_std(9, 8'd5, 8'd7, 8'd13, 8'd15);
        check_outputs("abort9");

        // Abort right after beat 13: its pending pooled output must vanish
        send_frame(16'sd0, 1'b1, 1'b0, 14);
        send_frame(16'sd0, 1'b1, 1'b0, 16);
        step(4);
        push_exp(5, 8'd5, 8'd0, 8'd0, 1'b0);
        push_exp(7, 8'd7, 8'd0, 8'd1, 1'b0);
        push_std(14, 8'd5, 8'd7, 8'd13, 8'd15);
        check_outputs("abort14");

        // Asynchronous reset while an output is being presented
        send_frame(16'sd0, 1'b1, 1'b0, 6);
        step(1);
        check("areset.pre_valid", 32'(bus.out_valid), 32'd1);
        check("areset.pre_data",  32'(bus.out_data), 32'd5);
        check("areset.pre_busy",  32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_zero_outputs("areset");
        #2 rst = 1'b1;
        step(3);
        check("areset.post_valid", 32'(bus.out_valid), 32'd0);
        mon_q.delete();
        beat_q.delete();

        check("stray_done", 32'(stray_done), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/relu_maxpool_2x2.md
Name: relu_maxpool_2x2

Overview:
- Downstream stage of the 4-PE conv engine.
- Consumes the raw per-pixel convolution sum stream (valid pixels only, padding columns already gated off by the producer's write flag).
- Adds the per-output-channel bias, applies ReLU, rescales and saturates to 8 bits, then performs 2x2 stride-2 max pooling.
- Emits a raster stream of pooled 8-bit pixels, one output channel per frame, for the next layer's buffer/BMP writer.

Parameters:
- IMG_W, 224, input frame width in pixels; must be even, >= 2.
- IMG_H, 224, input frame height in pixels; must be even, >= 2.
- SHIFT, 4, right-shift applied after ReLU, before saturation.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse; starts a new frame and latches bias_in.
- bias_in  input  16  signed channel bias, sampled only when frame_start=1.
- in_valid  input  1  in_data carries the next raster pixel.
- in_data  input  36  signed convolution sum without bias.
- out_valid  output  1  out_data/out_row/out_col valid this cycle.
- out_data  output  8  pooled unsigned pixel.
- out_row  output  8  pooled row index, 0..IMG_H/2-1.
- out_col  output  8  pooled column index, 0..IMG_W/2-1.
- frame_done  output  1  one-cycle pulse with the last pooled pixel of a frame.
- busy  output  1  high while in RUN state.

Behaviour:
- Reset: every output is 0; state IDLE; all counters 0; latched bias 0; pipeline valid flags 0.
  - The row buffer contents need not be reset; they are always written before being read.
- State machine: IDLE, RUN, DONE.
  - frame_start in any state -> RUN: col/row counters cleared, pipeline valids cleared, bias latched.
  - RUN -> DONE on acceptance of beat IMG_W*IMG_H-1.
  - DONE and IDLE hold until the next frame_start.
  - in_valid in IDLE/DONE is ignored; no output is produced.
- frame_start and in_valid in the same cycle: that beat is pixel (0,0) of the new frame and uses bias_in from that same cycle.
- Column/row counters: col wraps IMG_W-1 -> 0 and increments row; advance only on accepted beats. Gaps in in_valid are allowed anywhere.
- Stage 1, registered one cycle after acceptance:
  - s = in_data + sign-extended bias, 37-bit signed.
  - r = (s < 0) ? 0 : s.
  - q = r >> SHIFT.
  - q is clamped to 255 if greater than 255.
  - Stage 1 carries q plus its col/row parity and col>>1.
- Stage 2:
  - Even col: hold q in h_reg.
  - Odd col: hmax = max(h_reg, q).
  - Even row, odd col: row_buf[col>>1] <= hmax. row_buf is IMG_W/2 x 8 bits.
  - Odd row, odd col: out_data <= max(row_buf[col>>1], hmax); out_valid <= 1; out_row <= row>>1; out_col <= col>>1.
- Latency: out_valid rises exactly 2 clk after the accepted beat at (odd row, odd col). Otherwise out_valid = 0.
- out_data/out_row/out_col hold their last values when out_valid = 0.
- frame_done is asserted in the same cycle as the out_valid for pooled pixel (IMG_H/2-1, IMG_W/2-1).
- frame_start mid-frame aborts the frame:
  - Any in-flight stage 1/2 results are discarded; no out_valid or frame_done is produced from them.
  - Counters restart immediately.
- Reset mid-frame returns to the reset values above immediately (asynchronous).
- Throughput: one input beat per cycle sustained; no backpressure.

Optional Feature:
- Macro RELU_POOL_SAT_CNT_EN.
- When defined:
  - Adds output sat_cnt [17:0], the count of stage-1 pixels that were clamped to 255 in the current frame.
  - Cleared to 0 on reset and on frame_start.
  - Saturates at 2^18-1; remains stable after frame_done until the next frame_start.
- When not defined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=4, SHIFT=4, bias=0. Frame of 16 back-to-back beats with in_data = 16*k for k=0..15 (q=k) -> 4 outputs (0,0)=5, (0,1)=7, (1,0)=13, (1,1)=15; frame_done coincides with (1,1); each out_valid is 2 cycles after beats 5, 7, 13, 15; busy drops after beat 15.
- ReLU/bias: bias=-32, all in_data=16 -> s=-16 -> all outputs 0. Then bias=+16, in_data=-16 -> all outputs 0. Then bias=+16, in_data=16 -> s=32 -> all outputs 2.
- Saturation: in_data=36'sh0_0001_0000, bias=0 -> q clamps to 255 and every output is 255. With RELU_POOL_SAT_CNT_EN, sat_cnt=16 at frame_done.
- Gapped input: same data as the first test with in_valid toggling 1,0,0,1,... -> identical output values and indices; each out_valid is still 2 cycles after its triggering beat.
- Abort: frame_start asserted at beat 9 of a 4x4 frame, together with a new pixel (0,0) -> no out_valid from the old frame after the abort; the new frame's first output comes 2 cycles after its beat 5 with row=0, col=0.
- Idle: in_valid pulses after frame_done with no frame_start -> out_valid stays 0 and counters are unchanged. Async rst low mid-frame -> all outputs 0 without waiting for a clk edge.
